cache_refill_ctrl: RTL

//  Memory-stage controller for the data cache: sequences load-miss refills and write-through stores against
//  a variable-latency main-memory port (req/ready handshake), drives the cache fill port and stalls the pipeline.

---
 rtl/cache_ctrl_pkg.sv | 15 +
 rtl/cache_refill_ctrl_sat_counter.sv | 22 ++
 rtl/cache_refill_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the data-cache refill controller.
// Imported by the controller top and its saturating counter.
package cache_ctrl_pkg;

   localparam int DATA_WIDTH_DEF    = 32;
   localparam int COUNTER_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      FILL    = 2'd2,
      WR_WAIT = 2'd3
   } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_sat_counter.sv
// Saturating up-counter used for the cache hit/miss performance counters.
// Holds at all-ones instead of wrapping; synchronous active-high clear.
module sat_counter
   import cache_ctrl_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Memory-stage refill/write-through controller: sequences load-miss refills and
// stores against a req/ready memory port, owns the cache fill port and StallM.
module cache_refill_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     MemReadM,
   input  logic                     MemWriteM,
   input  logic                     useCacheM,
   input  logic [DATA_WIDTH-1:0]    AddrM,
   input  logic [DATA_WIDTH-1:0]    WriteDataM,
   input  logic                     cachehitM,
   input  logic [DATA_WIDTH-1:0]    cacheDataM,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [DATA_WIDTH-1:0]    mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic                     mem_ready,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     fill_we,
   output logic [DATA_WIDTH-1:0]    fill_addr,
   output logic [DATA_WIDTH-1:0]    fill_data,
   output logic                     StallM,
   output logic [DATA_WIDTH-1:0]    ReadDataOutM,
   output logic [COUNTER_WIDTH-1:0] hit_cnt,
   output logic [COUNTER_WIDTH-1:0] miss_cnt
);

   refill_state_t         state_p1, state_d;
   logic [DATA_WIDTH-1:0] addr_p1;
   logic [DATA_WIDTH-1:0] wdata_p1;
   logic [DATA_WIDTH-1:0] rbuf_p1;
   logic                  cacheable_p1;
   logic                  wr_hit_p1;

   logic latch_rd, latch_wr, capture_rd;
   logic hit_inc, miss_inc;

   // Stage p1: FSM state and transaction latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1     <= IDLE;
         addr_p1      <= '0;
         wdata_p1     <= '0;
         rbuf_p1      <= '0;
         cacheable_p1 <= 1'b0;
         wr_hit_p1    <= 1'b0;
      end else begin
         state_p1 <= state_d;
         if (latch_rd) begin
            addr_p1      <= AddrM;
            cacheable_p1 <= useCacheM;
         end
         if (latch_wr) begin
            addr_p1   <= AddrM;
            wdata_p1  <= WriteDataM;
            wr_hit_p1 <= cachehitM & useCacheM;
         end
         if (capture_rd) begin
            rbuf_p1 <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d      = state_p1;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      fill_we      = 1'b0;
      fill_addr    = '0;
      fill_data    = '0;
      StallM       = 1'b0;
      ReadDataOutM = '0;
      latch_rd     = 1'b0;
      latch_wr     = 1'b0;
      capture_rd   = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;

      unique case (state_p1)
         IDLE: begin
            // A load wins over a store when both are flagged in the same cycle.
            if (MemReadM) begin
               if (useCacheM && cachehitM) begin
                  ReadDataOutM = cacheDataM;
                  hit_inc      = 1'b1;
               end else begin
                  StallM   = 1'b1;
                  latch_rd = 1'b1;
                  miss_inc = useCacheM;
                  state_d  = RD_WAIT;
               end
            end else if (MemWriteM) begin
               StallM   = 1'b1;
               latch_wr = 1'b1;
               state_d  = WR_WAIT;
            end
         end

         RD_WAIT: begin
            mem_req  = 1'b1;
            mem_addr = addr_p1;
            StallM   = 1'b1;
            if (mem_ready) begin
               capture_rd = 1'b1;
               state_d    = FILL;
            end
         end

         FILL: begin
            // Single cycle: the pipeline advances while the line is written.
            fill_we      = cacheable_p1;
            fill_addr    = addr_p1;
            fill_data    = rbuf_p1;
            ReadDataOutM = rbuf_p1;
            state_d      = IDLE;
         end

         WR_WAIT: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_p1;
            mem_wdata = wdata_p1;
            StallM    = !mem_ready;
            // Write-through, no-write-allocate: only update a line already present.
            if (mem_ready) begin
               fill_we   = wr_hit_p1;
               fill_addr = addr_p1;
               fill_data = wdata_p1;
               state_d   = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_cnt)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_cnt)
   );

endmodule
